// File: rtl/arbiter_types.sv
// Shared types for the I/D cacheline arbiter: FSM states, grant side,
// memory operation encoding and line-offset helpers.
package arbiter_types;

   typedef enum logic [2:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      DONE_I,
      DONE_D
   } arb_state_t;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } grant_t;

   // Number of byte-offset bits inside one cacheline of the given width.
   function automatic int offset_bits(input int line_width);
      return $clog2(line_width / 8);
   endfunction

   localparam int LINE_WIDTH_DEFAULT = 256;
   localparam int ADDR_WIDTH_DEFAULT = 32;
   localparam int OFFSET_BITS        = offset_bits(LINE_WIDTH_DEFAULT);

endpackage

// File: rtl/cacheline_arbiter.sv
// Shares one physical-memory cacheline port between the I-cache and the
// D-cache miss ports. One transaction at a time; ties alternate sides.
module cacheline_arbiter
   import arbiter_types::*;
#(
   parameter int LINE_WIDTH = LINE_WIDTH_DEFAULT,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   // I-cache side
   input  logic                  i_pmem_read,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   // D-cache side
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   // memory side
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   localparam int LINE_OFFSET = offset_bits(LINE_WIDTH);

   // Request captured at grant; requester inputs are ignored afterwards.
   typedef struct packed {
      logic                  wr;
      logic [ADDR_WIDTH-1:0] addr;
      logic [LINE_WIDTH-1:0] wdata;
   } req_t;

   arb_state_t            state, state_next;
   grant_t                last_grant;
   req_t                  req_q;
   logic [LINE_WIDTH-1:0] line_buf;
   logic                  i_req, d_req;

   assign i_req = i_pmem_read;
   assign d_req = d_pmem_read | d_pmem_write;

   // Address/data come straight from the request latch, so they are
   // registered and stay stable for the whole memory command.
   assign mem_address  = req_q.addr;
   assign mem_wdata    = req_q.wdata;
   assign i_pmem_rdata = line_buf;
   assign d_pmem_rdata = line_buf;

   // Next state: grant in IDLE (ties go opposite last_grant), wait for memory, one DONE cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (i_req && d_req)
               state_next = (last_grant == GRANT_I) ? SERVE_D : SERVE_I;
            else if (d_req)
               state_next = SERVE_D;
            else if (i_req)
               state_next = SERVE_I;
         end
         SERVE_I: if (mem_resp) state_next = DONE_I;
         SERVE_D: if (mem_resp) state_next = DONE_D;
         DONE_I,
         DONE_D:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, request latch, memory commands and response pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= GRANT_I;
         req_q       <= '0;
         line_buf    <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         i_pmem_resp <= 1'b0;
         d_pmem_resp <= 1'b0;
      end else begin
         state       <= state_next;
         i_pmem_resp <= 1'b0;
         d_pmem_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (state_next == SERVE_I) begin
                  last_grant <= GRANT_I;
                  req_q.wr   <= 1'b0;
                  req_q.addr <= i_pmem_address;
                  mem_read   <= 1'b1;
               end else if (state_next == SERVE_D) begin
                  // write wins if a D request (illegally) raises both
                  last_grant  <= GRANT_D;
                  req_q.wr    <= d_pmem_write;
                  req_q.addr  <= d_pmem_address;
                  req_q.wdata <= d_pmem_wdata;
                  mem_read    <= ~d_pmem_write;
                  mem_write   <= d_pmem_write;
               end
            end
            SERVE_I,
            SERVE_D: begin
               if (mem_resp) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (!req_q.wr)
                     line_buf <= mem_rdata;
                  if (state == SERVE_I)
                     i_pmem_resp <= 1'b1;
                  else
                     d_pmem_resp <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // A D request may not read and write at the same time.
   a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(d_pmem_read && d_pmem_write));

   // Line addresses arrive aligned to a cacheline.
   a_i_aligned: assert property (@(posedge clk) disable iff (rst)
      i_pmem_read |-> (i_pmem_address[LINE_OFFSET-1:0] == '0));
   a_d_aligned: assert property (@(posedge clk) disable iff (rst)
      d_req |-> (d_pmem_address[LINE_OFFSET-1:0] == '0));

endmodule
